floor_request_queue: RTL

Memory-mapped floor-request controller between the MIPS MEM stage and the elevator controller. Store instructions push floor numbers into a FIFO of pending requests. The block hands requests to the elevator one at a time over a valid/ack handshake, then waits for arrival before issuing the next one. Loads read queue status, the head entry and the current floor, so software can poll progress without stalling the pipeline.

---
 rtl/floor_request_queue.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/floor_request_queue.sv
// floor_request_queue
//
// Memory-mapped floor-request controller between the MIPS MEM stage and the
// elevator controller. Stores push floor numbers into a circular FIFO of
// pending requests. One request at a time is offered to the elevator, which
// accepts it and later reports arrival. Loads return queue status, the head
// entry and the elevator's current floor without stalling the pipeline.
//
// Register map (byte offsets from BASE_ADDR, decoded with i_addr[3:2] once
// i_addr[31:4] matches):
//   +0x0 REQ     W: push i_wdata[FLOOR_W-1:0]   R: head entry (0 if empty)
//   +0x4 STATUS  R: [15:8] count, [4] err, [3] done_sticky, [2] busy,
//                   [1] full, [0] empty
//   +0x8 CURRENT R: zero-extended i_current_floor
//   +0xC CTRL    W: bit0 flush queue, bit1 clear done_sticky and err  R: 0
//
// Handshake: o_req_valid rises with o_target_floor and both hold steady
// until the elevator raises i_req_ack for one cycle; the request is
// transferred on the rising edge where o_req_valid and i_req_ack are both
// high, and o_req_valid is low from the next cycle. The elevator then pulses
// i_arrived once; o_done pulses for one cycle after that. i_req_ack is
// ignored outside REQUEST and i_arrived is ignored outside SERVING.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_addr, i_wdata     MEM-stage byte address and store data
//   i_we                MEM-stage store strobe
//   o_rdata             combinational load data (0 when the address misses)
//   o_target_floor      floor offered to the elevator
//   o_req_valid         o_target_floor is valid
//   i_req_ack           elevator accepts the offered floor
//   i_arrived           one-cycle pulse, elevator reached the accepted floor
//   i_current_floor     elevator's present floor
//   o_done              one-cycle pulse when a request completes
//   o_fsm_state         debug view of the FSM state (0 idle, 1 request, 2 serving)

module floor_request_queue #(
    parameter int          DEPTH      = 8,
    parameter int          FLOOR_W    = 3,
    parameter int          NUM_FLOORS = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0040
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  logic               i_we,
    output logic [31:0]        o_rdata,
    output logic [FLOOR_W-1:0] o_target_floor,
    output logic               o_req_valid,
    input  logic               i_req_ack,
    input  logic               i_arrived,
    input  logic [FLOOR_W-1:0] i_current_floor,
    output logic               o_done,
    output logic [1:0]         o_fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVING = 2'd2
    } state_t;

    state_t             state_q;
    logic [FLOOR_W-1:0] target_q;
    logic               req_valid_q;
    logic               done_q;
    logic               err_q;
    logic               done_sticky_q;

    logic [FLOOR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Bus decode
    logic               addr_hit;
    logic [1:0]         reg_sel;
    logic               req_wr, ctrl_wr, flush, clr_flags;
    logic [FLOOR_W-1:0] push_floor;
    logic               floor_oor;

    // Queue status and pop sources
    logic               empty, full, busy;
    logic [FLOOR_W-1:0] head;
    logic               pop_idle, pop_ack, pop;
    logic               dup, push_ok, push_err;
    logic [31:0]        status_word;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^i_addr[1:0];

    assign addr_hit   = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = i_addr[3:2];
    assign req_wr     = i_we && addr_hit && (reg_sel == 2'd0);
    assign ctrl_wr    = i_we && addr_hit && (reg_sel == 2'd3);
    assign flush      = ctrl_wr && i_wdata[0];
    assign clr_flags  = ctrl_wr && i_wdata[1];
    assign push_floor = i_wdata[FLOOR_W-1:0];
    // Range check uses the full store word so an oversize value cannot alias
    // onto a legal floor through truncation.
    assign floor_oor  = (i_wdata >= 32'(NUM_FLOORS));

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign busy  = (state_q != ST_IDLE);
    assign head  = mem_q[rd_ptr_q];

    // Head already at the elevator's floor completes without a handshake.
    assign pop_idle = (state_q == ST_IDLE) && !empty && (head == i_current_floor);
    assign pop_ack  = (state_q == ST_REQUEST) && i_req_ack;
    assign pop      = pop_idle || pop_ack;

    // Duplicate check against every live entry plus the in-flight target.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (mem_q[rd_ptr_q + PTR_W'(i)] == push_floor)) begin
                dup = 1'b1;
            end
        end
        if (((state_q == ST_REQUEST) || (state_q == ST_SERVING)) && (target_q == push_floor)) begin
            dup = 1'b1;
        end
    end

    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok  = req_wr && !flush && !floor_oor && !(full && !pop) && !dup;
    assign push_err = req_wr && !flush && (floor_oor || (full && !pop));

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_floor;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            req_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            done_sticky_q <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= 1'b0;

            if (clr_flags) begin
                err_q         <= 1'b0;
                done_sticky_q <= 1'b0;
            end
            if (push_err) err_q <= 1'b1;

            // A completion in the same cycle as a clear still sets the
            // sticky bit (later assignment wins) so no event is lost.
            case (state_q)
                ST_IDLE: begin
                    if (pop_idle) begin
                        done_q        <= 1'b1;
                        done_sticky_q <= 1'b1;
                    end else if (!empty && !flush) begin
                        target_q    <= head;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    // Ack beats flush: the accepted floor is still served.
                    if (i_req_ack) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_SERVING;
                    end else if (flush) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_SERVING: begin
                    if (i_arrived) begin
                        done_q        <= 1'b1;
                        done_sticky_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign status_word = {16'd0, 8'(count_q), 3'd0, err_q, done_sticky_q, busy, full, empty};

    always_comb begin
        o_rdata = '0;
        if (addr_hit) begin
            case (reg_sel)
                2'd0:    o_rdata = empty ? 32'd0 : 32'(head);
                2'd1:    o_rdata = status_word;
                2'd2:    o_rdata = 32'(i_current_floor);
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_target_floor = target_q;
    assign o_req_valid    = req_valid_q;
    assign o_done         = done_q;
    assign o_fsm_state    = state_q;

endmodule
